// File: rtl/mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : mux8_rr_sched
// Description : Round-robin scheduler sharing one 8:1 enable-gated mux
//               between 8 requesters. Drives registered select/enable and
//               a one-hot grant back to the requesters. A grant lasts while
//               the owner holds its request; on release the next pending
//               requester is granted at the same edge.
//               Optional macro MUX8_SCHED_TIMEOUT_EN bounds every grant to
//               HOLD_MAX cycles and pulses timeout on a forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_sched #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic       en,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_ptr;
    logic [2:0]  w_ptr_nxt;
    logic [2:0]  r_sel;
    logic [2:0]  w_sel_nxt;
    logic        r_en;
    logic        w_en_nxt;
    logic [7:0]  r_gnt;
    logic [7:0]  w_gnt_nxt;
    logic        w_grant_new;
    logic        w_timeout_nxt;

    logic        w_force;
    logic        w_release;
    logic [2:0]  w_scan_start;
    logic [7:0]  w_mask;
    logic [7:0]  w_cand;
    logic        w_found;
    logic [2:0]  w_win;

    // Rotating-priority pick: first set bit of cand scanning from start
    // upward, wrapping modulo 8. Returns {found, index}.
    function automatic logic [3:0] f_pick(input logic [7:0] cand,
                                          input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] j;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            j = start + 3'(k);
            if (!found && cand[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

`ifdef MUX8_SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout;

    // Forced release once the owner has held the path for HOLD_MAX cycles.
    assign w_force = (r_state == ST_GRANT) && req[r_sel] &&
                     (r_hold_cnt == CNT_W'(HOLD_MAX - 1));

    // Hold counter: cleared on every new grant, counts while a grant is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_grant_new) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_GRANT) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // One-cycle pulse following a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    // Sizing parameters only matter when grants are bounded.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(HOLD_MAX), 32'(CNT_W), w_timeout_nxt};
    assign w_force      = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Release: owner dropped its request, or its time budget expired.
    assign w_release    = (r_state == ST_GRANT) && (!req[r_sel] || w_force);
    // On a release the search starts just after the released owner, which
    // is exactly the new ptr value; in IDLE it starts at the stored ptr.
    assign w_scan_start = (r_state == ST_GRANT) ? (r_sel + 3'd1) : r_ptr;
    // The released index sits out only the arbitration at its release edge.
    assign w_mask       = w_release ? (8'b1 << r_sel) : 8'b0;
    assign w_cand       = req & ~w_mask;
    assign {w_found, w_win} = f_pick(w_cand, w_scan_start);

    // Next-state and next-output decode for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_en_nxt      = r_en;
        w_gnt_nxt     = r_gnt;
        w_grant_new   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arb_en && w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_en_nxt    = 1'b1;
                    w_gnt_nxt   = 8'b1 << w_win;
                    w_grant_new = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt     = r_sel + 3'd1;
                    w_timeout_nxt = w_force;
                    if (arb_en && w_found) begin
                        // Back-to-back hand-over, no dead cycle on en.
                        w_sel_nxt   = w_win;
                        w_gnt_nxt   = 8'b1 << w_win;
                        w_grant_new = 1'b1;
                    end else begin
                        // sel keeps its last value while idle.
                        w_state_nxt = ST_IDLE;
                        w_en_nxt    = 1'b0;
                        w_gnt_nxt   = 8'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_en_nxt    = 1'b0;
                w_gnt_nxt   = 8'b0;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_en    <= 1'b0;
            r_gnt   <= 8'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign gnt  = r_gnt;
    assign busy = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux8_rr_sched
// Description : Scoreboard bench for mux8_rr_sched. A driver applies
//               directed and random stimulus on the falling edge and pushes
//               the reference model's expected outputs into a queue; a
//               monitor pops and compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_sched;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 5;
`ifdef MUX8_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       arb_en;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    mux8_rr_sched #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .req     (req),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic [7:0] gnt;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model: who owns the mux (-1 = nobody), last index shown on
    // sel, where the next search starts, and how long the owner has held.
    int m_owner = -1;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    function automatic int first_req(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic a);
        logic [7:0] rest;
        bit         forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (a && r != 8'h00) begin
                m_owner = first_req(r, m_ptr);
                m_sel   = m_owner;
                m_hold  = 0;
            end
        end else begin
            forced = TO_EN && (m_hold == HOLD_MAX - 1) && r[m_owner];
            if (!r[m_owner] || forced) begin
                m_ptr = (m_owner + 1) % 8;
                m_to  = forced;
                rest  = r;
                rest[m_owner] = 1'b0;
                if (a && rest != 8'h00) begin
                    m_owner = first_req(rest, m_ptr);
                    m_sel   = m_owner;
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_hold++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.sel  = 3'(m_sel);
        e.en   = (m_owner >= 0);
        e.gnt  = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
        e.busy = (m_owner >= 0);
        e.to   = m_to;
        return e;
    endfunction

    // Apply one cycle of stimulus on the falling edge; rs=0 holds reset.
    task automatic drive(input logic [7:0] r, input logic a, input logic rs);
        exp_t z;
        @(negedge clk);
        req    = r;
        arb_en = a;
        if (!rs) begin
            if (rst_n) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if ({sel, en, gnt, busy, timeout} != 14'h0) begin
                    failures++;
                    $display("FAIL async_reset t=%0t got sel=%0d en=%b gnt=%h busy=%b to=%b exp all zero",
                             $time, sel, en, gnt, busy, timeout);
                end
            end
            model_reset();
            z = '0;
            sb.push_back(z);
        end else begin
            rst_n = 1'b1;
            model_step(r, a);
            sb.push_back(model_out());
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    always begin
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {sel, en, gnt, busy, timeout};
            checks++;
            if (g != e) begin
                failures++;
                $display("FAIL sb cyc=%0d got sel=%0d en=%b gnt=%h busy=%b to=%b exp sel=%0d en=%b gnt=%h busy=%b to=%b",
                         cyc, g.sel, g.en, g.gnt, g.busy, g.to,
                         e.sel, e.en, e.gnt, e.busy, e.to);
            end
        end
    end

    initial begin
        logic [7:0] done;
        logic [7:0] rv;
        logic       av;
        rst_n  = 1'b0;
        arb_en = 1'b0;
        req    = 8'h00;

        // Reset state.
        repeat (3) drive(8'h00, 1'b1, 1'b0);

        // Single requester, grant then release (ptr moves to 6).
        drive(8'h00, 1'b1, 1'b1);
        repeat (3) drive(8'h20, 1'b1, 1'b1);
        repeat (2) drive(8'h00, 1'b1, 1'b1);

        // All request, each drops right after its grant: order 0..7.
        repeat (2) drive(8'h00, 1'b1, 1'b0);
        done = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (m_owner >= 0) done[m_owner] = 1'b1;
            drive(8'hFF & ~done, 1'b1, 1'b1);
        end

        // Wrap: 0 wins over 7, 7 follows once 0 releases.
        repeat (3) drive(8'h81, 1'b1, 1'b1);
        repeat (2) drive(8'h80, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);

        // arb_en gating and arb_en falling mid-grant.
        repeat (3) drive(8'h04, 1'b0, 1'b1);
        drive(8'h04, 1'b1, 1'b1);
        repeat (3) drive(8'h04, 1'b0, 1'b1);
        repeat (2) drive(8'h00, 1'b0, 1'b1);

        // Two long holders: bounded only with the timeout feature.
        repeat (12) drive(8'h44, 1'b1, 1'b1);
        repeat (2) drive(8'h00, 1'b1, 1'b1);
        repeat (10) drive(8'h04, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);

        // Reset mid-grant, then re-grant right after reset release.
        repeat (2) drive(8'h08, 1'b1, 1'b1);
        drive(8'h08, 1'b1, 1'b0);
        repeat (2) drive(8'h08, 1'b1, 1'b1);
        drive(8'h00, 1'b1, 1'b1);

        // Random traffic with occasional arb_en drops and resets.
        rv = 8'h00;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(3) == 0) rv[b] = ~rv[b];
            end
            av = ($urandom_range(9) != 0);
            drive(rv, av, ($urandom_range(99) != 0));
        end

        repeat (2) drive(8'h00, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
